uart_fifo_bridge: RTL and testbench

//  Next-generation UART buffering layer between uart_rx/uart_tx and the system side.

---
 rtl/uart_fifo_pkg.sv | 18 +
 rtl/fifo_core.sv | 104 ++++++++++
 rtl/uart_fifo_bridge.sv | 109 ++++++++++
 tb/tb_uart_fifo_bridge.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared constants for the UART buffering layer.
// Holds the default channel geometry and the bit positions of the sticky
// error vector that the top level exports on o_err.
package uart_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int RX_DEPTH_DEF   = 16;
    localparam int TX_DEPTH_DEF   = 16;
    localparam int RX_AF_LVL_DEF  = 12;
    localparam int TX_AE_LVL_DEF  = 2;

    localparam int ERR_W      = 4;
    localparam int ERR_RX_OVF = 0;
    localparam int ERR_RX_UDF = 1;
    localparam int ERR_TX_OVF = 2;
    localparam int ERR_TX_UDF = 3;

endpackage : uart_fifo_pkg

// File: rtl/fifo_core.sv
// Single-clock first-word-fall-through FIFO used for each UART channel.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   write_i, data_i       push request and word
//   read_i                pop request; data_o always shows the head word
//   flush_i               synchronous empty, overrides read/write
//   count_o               occupancy 0..DEPTH
//   empty_o/full_o        registered status
//   afull_o/aempty_o      registered threshold status
//   ovf_pulse_o           one-cycle pulse: write dropped because full
//   udf_pulse_o           one-cycle pulse: read while empty
module fifo_core #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LVL     = 12,
    parameter int AE_LVL     = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      write_i,
    input  logic                      read_i,
    input  logic                      flush_i,
    input  logic [DATA_WIDTH-1:0]     data_i,
    output logic [DATA_WIDTH-1:0]     data_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic                      afull_o,
    output logic                      aempty_o,
    output logic                      ovf_pulse_o,
    output logic                      udf_pulse_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  empty_q, full_q, afull_q, aempty_q;
    logic                  do_push, do_pop;

    always_comb begin
        do_push     = 1'b0;
        do_pop      = 1'b0;
        ovf_pulse_o = 1'b0;
        udf_pulse_o = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            do_pop      = read_i && !empty_q;
            // A full FIFO still accepts a word when a pop frees the slot in
            // the same cycle; an empty one accepts it even though the read is
            // rejected.
            do_push     = write_i && (!full_q || read_i);
            ovf_pulse_o = write_i && full_q && !read_i;
            udf_pulse_o = read_i && empty_q;

            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == CW'(DEPTH));
            afull_q  <= (count_d >= CW'(AF_LVL));
            aempty_q <= (count_d <= CW'(AE_LVL));
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o   = mem_q[rd_ptr_q];
    assign count_o  = count_q;
    assign empty_o  = empty_q;
    assign full_o   = full_q;
    assign afull_o  = afull_q;
    assign aempty_o = aempty_q;

endmodule : fifo_core

// File: rtl/uart_fifo_bridge.sv
// UART buffering layer: an RX FIFO (uart_rx -> system) and a TX FIFO
// (system -> uart_tx), both FWFT, plus a sticky error register.
// Ports:
//   i_clock, i_reset                       clock, asynchronous active-low reset
//   i_rx_data/i_rx_write/i_rx_read/i_rx_flush   RX channel control
//   o_rx_data/o_rx_count/o_rx_empty/o_rx_full/o_rx_afull  RX head and status
//   i_tx_data/i_tx_write/i_tx_read/i_tx_flush   TX channel control
//   o_tx_data/o_tx_count/o_tx_empty/o_tx_full/o_tx_aempty TX head and status
//   i_clr_err                               clear sticky errors
//   o_err                                   sticky {tx_udf, tx_ovf, rx_udf, rx_ovf}
module uart_fifo_bridge
    import uart_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RX_DEPTH   = RX_DEPTH_DEF,
    parameter int TX_DEPTH   = TX_DEPTH_DEF,
    parameter int RX_AF_LVL  = RX_AF_LVL_DEF,
    parameter int TX_AE_LVL  = TX_AE_LVL_DEF
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [DATA_WIDTH-1:0]      i_rx_data,
    input  logic                       i_rx_write,
    input  logic                       i_rx_read,
    input  logic                       i_rx_flush,
    output logic [DATA_WIDTH-1:0]      o_rx_data,
    output logic [$clog2(RX_DEPTH):0]  o_rx_count,
    output logic                       o_rx_empty,
    output logic                       o_rx_full,
    output logic                       o_rx_afull,
    input  logic [DATA_WIDTH-1:0]      i_tx_data,
    input  logic                       i_tx_write,
    input  logic                       i_tx_read,
    input  logic                       i_tx_flush,
    output logic [DATA_WIDTH-1:0]      o_tx_data,
    output logic [$clog2(TX_DEPTH):0]  o_tx_count,
    output logic                       o_tx_empty,
    output logic                       o_tx_full,
    output logic                       o_tx_aempty,
    input  logic                       i_clr_err,
    output logic [ERR_W-1:0]           o_err
);

    logic rx_ovf, rx_udf, tx_ovf, tx_udf;
    logic rx_aempty_unused, tx_afull_unused;
    logic [ERR_W-1:0] err_set, err_q, err_d;

    fifo_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RX_DEPTH),
        .AF_LVL     (RX_AF_LVL),
        .AE_LVL     (0)
    ) u_rx_fifo (
        .clk_i       (i_clock),
        .rst_ni      (i_reset),
        .write_i     (i_rx_write),
        .read_i      (i_rx_read),
        .flush_i     (i_rx_flush),
        .data_i      (i_rx_data),
        .data_o      (o_rx_data),
        .count_o     (o_rx_count),
        .empty_o     (o_rx_empty),
        .full_o      (o_rx_full),
        .afull_o     (o_rx_afull),
        .aempty_o    (rx_aempty_unused),
        .ovf_pulse_o (rx_ovf),
        .udf_pulse_o (rx_udf)
    );

    fifo_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (TX_DEPTH),
        .AF_LVL     (TX_DEPTH),
        .AE_LVL     (TX_AE_LVL)
    ) u_tx_fifo (
        .clk_i       (i_clock),
        .rst_ni      (i_reset),
        .write_i     (i_tx_write),
        .read_i      (i_tx_read),
        .flush_i     (i_tx_flush),
        .data_i      (i_tx_data),
        .data_o      (o_tx_data),
        .count_o     (o_tx_count),
        .empty_o     (o_tx_empty),
        .full_o      (o_tx_full),
        .afull_o     (tx_afull_unused),
        .aempty_o    (o_tx_aempty),
        .ovf_pulse_o (tx_ovf),
        .udf_pulse_o (tx_udf)
    );

    always_comb begin
        err_set             = '0;
        err_set[ERR_RX_OVF] = rx_ovf;
        err_set[ERR_RX_UDF] = rx_udf;
        err_set[ERR_TX_OVF] = tx_ovf;
        err_set[ERR_TX_UDF] = tx_udf;
        // New events win over a clear arriving in the same cycle.
        err_d = (i_clr_err ? '0 : err_q) | err_set;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) err_q <= '0;
        else          err_q <= err_d;
    end

    assign o_err = err_q;

endmodule : uart_fifo_bridge

// File: tb/tb_uart_fifo_bridge.sv
module tb_uart_fifo_bridge;

    localparam int RXD = 16;
    localparam int TXD = 16;
    localparam int AF  = 12;
    localparam int AE  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_d, tx_d;
    logic       rx_w, rx_r, rx_f, tx_w, tx_r, tx_f, clr;
    logic [7:0] o_rx_data, o_tx_data;
    logic [4:0] o_rx_count, o_tx_count;
    logic       o_rx_empty, o_rx_full, o_rx_afull;
    logic       o_tx_empty, o_tx_full, o_tx_aempty;
    logic [3:0] o_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [3:0] exp_err = 4'h0;

    always #5 clk = ~clk;

    uart_fifo_bridge dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_rx_data   (rx_d),
        .i_rx_write  (rx_w),
        .i_rx_read   (rx_r),
        .i_rx_flush  (rx_f),
        .o_rx_data   (o_rx_data),
        .o_rx_count  (o_rx_count),
        .o_rx_empty  (o_rx_empty),
        .o_rx_full   (o_rx_full),
        .o_rx_afull  (o_rx_afull),
        .i_tx_data   (tx_d),
        .i_tx_write  (tx_w),
        .i_tx_read   (tx_r),
        .i_tx_flush  (tx_f),
        .o_tx_data   (o_tx_data),
        .o_tx_count  (o_tx_count),
        .o_tx_empty  (o_tx_empty),
        .o_tx_full   (o_tx_full),
        .o_tx_aempty (o_tx_aempty),
        .i_clr_err   (clr),
        .o_err       (o_err)
    );

    typedef struct {
        logic       rxw, rxr, rxf;
        logic [7:0] rxd;
        logic       txw, txr, txf;
        logic [7:0] txd;
        logic       clr;
        int         exp_rxc;
        int         exp_txc;
        logic [3:0] exp_err;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_status();
        chk("rx_count",  32'(o_rx_count), 32'(rxq.size()));
        chk("rx_empty",  32'(o_rx_empty), 32'(rxq.size() == 0));
        chk("rx_full",   32'(o_rx_full),  32'(rxq.size() == RXD));
        chk("rx_afull",  32'(o_rx_afull), 32'(rxq.size() >= AF));
        chk("tx_count",  32'(o_tx_count), 32'(txq.size()));
        chk("tx_empty",  32'(o_tx_empty), 32'(txq.size() == 0));
        chk("tx_full",   32'(o_tx_full),  32'(txq.size() == TXD));
        chk("tx_aempty", 32'(o_tx_aempty), 32'(txq.size() <= AE));
        chk("err",       32'(o_err),      32'(exp_err));
        if (rxq.size() > 0) chk("rx_fwft", 32'(o_rx_data), 32'(rxq[0]));
        if (txq.size() > 0) chk("tx_fwft", 32'(o_tx_data), 32'(txq[0]));
    endtask

    // One clock of stimulus; the scoreboard is updated as stimulus is driven
    // and popped entries are compared against the head the DUT presents.
    task automatic step(input logic rxw, input logic rxr, input logic rxf, input logic [7:0] rxdv,
                        input logic txw, input logic txr, input logic txf, input logic [7:0] txdv,
                        input logic clrv);
        int rxn, txn;
        logic [3:0] set;
        logic [7:0] front;
        rxn = rxq.size();
        txn = txq.size();
        set = 4'h0;
        if (rxf) rxq.delete();
        else begin
            if (rxr && rxn > 0) begin
                front = rxq.pop_front();
                chk("rx_pop", 32'(o_rx_data), 32'(front));
            end
            if (rxr && rxn == 0) set[1] = 1'b1;
            if (rxw && rxn == RXD && !rxr) set[0] = 1'b1;
            if (rxw && (rxn < RXD || rxr)) rxq.push_back(rxdv);
        end
        if (txf) txq.delete();
        else begin
            if (txr && txn > 0) begin
                front = txq.pop_front();
                chk("tx_pop", 32'(o_tx_data), 32'(front));
            end
            if (txr && txn == 0) set[3] = 1'b1;
            if (txw && txn == TXD && !txr) set[2] = 1'b1;
            if (txw && (txn < TXD || txr)) txq.push_back(txdv);
        end
        exp_err = (clrv ? 4'h0 : exp_err) | set;

        rx_w = rxw; rx_r = rxr; rx_f = rxf; rx_d = rxdv;
        tx_w = txw; tx_r = txr; tx_f = txf; tx_d = txdv;
        clr  = clrv;
        @(posedge clk);
        #1;
        rx_w = 0; rx_r = 0; rx_f = 0; tx_w = 0; tx_r = 0; tx_f = 0; clr = 0;
        check_status();
    endtask

    task automatic rx_push(input logic [7:0] d);
        step(1, 0, 0, d, 0, 0, 0, 8'h00, 0);
    endtask

    task automatic rx_pop();
        step(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0);
    endtask

    initial begin
        int toggles;
        logic prev_ae;

        rst_n = 0;
        rx_w = 0; rx_r = 0; rx_f = 0; rx_d = 0;
        tx_w = 0; tx_r = 0; tx_f = 0; tx_d = 0;
        clr  = 0;
        #12 rst_n = 1;

        // Reset state
        chk("rst_rx_empty",  32'(o_rx_empty),  32'd1);
        chk("rst_tx_aempty", 32'(o_tx_aempty), 32'd1);
        chk("rst_rx_count",  32'(o_rx_count),  32'd0);
        chk("rst_tx_count",  32'(o_tx_count),  32'd0);
        chk("rst_err",       32'(o_err),       32'd0);
        @(posedge clk);
        #1;

        // First push appears on the head one cycle later
        rx_push(8'hA5);
        chk("rx_a5_data",  32'(o_rx_data),  32'hA5);
        chk("rx_a5_count", 32'(o_rx_count), 32'd1);
        rx_pop();

        // Table of single-cycle vectors from an empty, error-free state
        //          rxw rxr rxf rxd    txw txr txf txd    clr rxc txc err
        tbl[0]  = '{0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 4'b0010};
        tbl[1]  = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 4'b0000};
        tbl[2]  = '{0, 0, 0, 8'h00, 1, 1, 0, 8'h3C, 0, 0, 1, 4'b1000};
        tbl[3]  = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 1, 4'b0000};
        tbl[4]  = '{0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 4'b0000};
        tbl[5]  = '{1, 0, 0, 8'h22, 1, 0, 0, 8'h11, 0, 1, 1, 4'b0000};
        tbl[6]  = '{1, 1, 1, 8'h33, 0, 0, 0, 8'h00, 0, 0, 1, 4'b0000};
        tbl[7]  = '{0, 0, 0, 8'h00, 0, 1, 1, 8'h00, 0, 0, 0, 4'b0000};
        tbl[8]  = '{0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 1, 0, 0, 4'b1000};
        tbl[9]  = '{1, 0, 0, 8'h44, 0, 0, 0, 8'h00, 1, 1, 0, 4'b0000};
        tbl[10] = '{0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 4'b0000};
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rxw, tbl[i].rxr, tbl[i].rxf, tbl[i].rxd,
                 tbl[i].txw, tbl[i].txr, tbl[i].txf, tbl[i].txd, tbl[i].clr);
            chk($sformatf("tbl%0d_rxc", i), 32'(o_rx_count), 32'(tbl[i].exp_rxc));
            chk($sformatf("tbl%0d_txc", i), 32'(o_tx_count), 32'(tbl[i].exp_txc));
            chk($sformatf("tbl%0d_err", i), 32'(o_err),      32'(tbl[i].exp_err));
            if (i == 2) chk("tbl2_txdata", 32'(o_tx_data), 32'h3C);
        end

        // Fill RX with 0x00..0x0F, overflow, drain in order
        for (int i = 0; i < 16; i++) begin
            rx_push(8'(i));
            if (i == 10) chk("afull_at_11", 32'(o_rx_afull), 32'd0);
            if (i == 11) chk("afull_at_12", 32'(o_rx_afull), 32'd1);
            if (i == 14) chk("full_at_15",  32'(o_rx_full),  32'd0);
        end
        chk("full_at_16", 32'(o_rx_full), 32'd1);
        rx_push(8'hEE);
        chk("ovf_17th", 32'(o_err[0]), 32'd1);
        for (int i = 0; i < 16; i++) rx_pop();
        chk("drained_empty", 32'(o_rx_empty), 32'd1);
        step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1);

        // Full RX with simultaneous write and read
        for (int i = 0; i < 16; i++) rx_push(8'(8'h20 + i));
        step(1, 1, 0, 8'h55, 0, 0, 0, 8'h00, 0);
        chk("fullrw_count", 32'(o_rx_count), 32'd16);
        chk("fullrw_ovf",   32'(o_err[0]),   32'd0);
        for (int i = 0; i < 15; i++) rx_pop();
        chk("fullrw_last", 32'(o_rx_data), 32'h55);
        rx_pop();

        // TX wrap with interleaved push/pop around the almost-empty level
        step(0, 0, 0, 8'h00, 1, 0, 0, 8'(101), 0);
        step(0, 0, 0, 8'h00, 1, 0, 0, 8'(102), 0);
        toggles = 0;
        for (int i = 0; i < 40; i++) begin
            prev_ae = o_tx_aempty;
            if (i % 2 == 0) step(0, 0, 0, 8'h00, 1, 0, 0, 8'($urandom_range(0, 255)), 0);
            else            step(0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0);
            if (o_tx_aempty != prev_ae) toggles++;
        end
        chk("tx_aempty_toggles", 32'(toggles), 32'd40);
        step(0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0);

        // Flush with a concurrent write at count 5
        for (int i = 0; i < 5; i++) rx_push(8'(8'h70 + i));
        step(1, 0, 1, 8'h99, 0, 0, 0, 8'h00, 0);
        chk("flush_count", 32'(o_rx_count), 32'd0);
        chk("flush_empty", 32'(o_rx_empty), 32'd1);
        chk("flush_err",   32'(o_err),      32'd0);

        // Asynchronous reset in the middle of a burst
        rx_pop();
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 8'(8'h80 + i), 1, 0, 0, 8'(8'h90 + i), 0);
        rx_w = 1; tx_w = 1; rx_d = 8'hAB; tx_d = 8'hCD;
        #2 rst_n = 0;
        #1;
        chk("arst_rx_count",  32'(o_rx_count),  32'd0);
        chk("arst_tx_count",  32'(o_tx_count),  32'd0);
        chk("arst_rx_empty",  32'(o_rx_empty),  32'd1);
        chk("arst_tx_empty",  32'(o_tx_empty),  32'd1);
        chk("arst_rx_afull",  32'(o_rx_afull),  32'd0);
        chk("arst_tx_aempty", 32'(o_tx_aempty), 32'd1);
        chk("arst_err",       32'(o_err),       32'd0);
        rx_w = 0; tx_w = 0;
        rxq.delete();
        txq.delete();
        exp_err = 4'h0;
        #3 rst_n = 1;
        @(posedge clk);
        #1;
        check_status();
        rx_push(8'h5A);
        rx_pop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_fifo_bridge
